// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - CPU-side load/store request bus for ram_access_ctrl
interface ram_access_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  ack, err, rdata, busy
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output ack, err, rdata, busy
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - byte/halfword/word load-store initiator for a synchronous word RAM
// Big-endian lanes; sub-word stores are read-modify-write through RD/CAP/WR.
module ram_access_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  ram_access_ctrl_if.slave  bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE} state_t;

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              req_bad;
  logic [31:0]       sh_b, sh_h, ext, lane_mask, lane_data, merged;

  // Offset 0 is the most significant lane, so shift right by (3-off) bytes.
  always_comb begin
    sh_b = ram_dout >> {~off_q, 3'b000};
    sh_h = ram_dout >> {~off_q[1], 4'b0000};
    case (size_q)
      2'b00: begin
        ext       = uns_q ? {24'h0, sh_b[7:0]} : {{24{sh_b[7]}}, sh_b[7:0]};
        lane_mask = 32'h0000_00FF << {~off_q, 3'b000};
        lane_data = {24'h0, wdata_q[7:0]} << {~off_q, 3'b000};
      end
      2'b01: begin
        ext       = uns_q ? {16'h0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
        lane_mask = 32'h0000_FFFF << {~off_q[1], 4'b0000};
        lane_data = {16'h0, wdata_q} << {~off_q[1], 4'b0000};
      end
      default: begin
        ext       = ram_dout;
        lane_mask = 32'h0;
        lane_data = 32'h0;
      end
    endcase
    merged = (ram_dout & ~lane_mask) | lane_data;
  end

  always_comb begin
    req_bad = (bus.size == 2'b11) ||
              (bus.size == 2'b01 && bus.addr[0]) ||
              (bus.size == 2'b10 && bus.addr[1:0] != 2'b00) ||
              ((bus.addr >> (ADDR_W + 2)) != 32'h0);
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: if (bus.req) begin
        we_d       = bus.we;
        size_d     = bus.size;
        uns_d      = bus.uns;
        off_d      = bus.addr[1:0];
        wdata_d    = bus.wdata[15:0];
        ram_addr_d = bus.addr[ADDR_W+1:2];
        if (req_bad) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else if (bus.we && bus.size == 2'b10) begin
          state_d   = WR;
          ram_we_d  = 1'b1;
          ram_din_d = bus.wdata;
        end else begin
          state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          state_d   = WR;
          ram_we_d  = 1'b1;
          ram_din_d = merged;
        end else begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = ext;
        end
      end
      WR: begin
        state_d = DONE;
        ack_d   = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= 32'h0;
      rdata_q    <= 32'h0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= 16'h0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Memory-side initiator that drives the 4096 x 32 single-port data RAM on behalf of the multi-cycle CPU. It accepts byte-addressed load/store requests of byte, halfword or word size, and converts them into word accesses on the RAM's synchronous port. Sub-word stores are done as read-modify-write. The block sits between the CPU datapath's memory stage and the RAM's `wea`/`addra`/`dina`/`douta` port, and handles alignment checking, lane placement and load sign extension.

## Interface
Parameters:
- `ADDR_W`, 12: RAM word-address width; byte space is 2^(ADDR_W+2) bytes.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous reset, active high.
- `req` in 1: request strobe, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word; 11 is illegal and raises an error.
- `uns` in 1: load zero-extends when 1, sign-extends when 0.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified for byte/halfword.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: valid with `ack`; request was misaligned, out of range, or had illegal size.
- `rdata` out 32: load result, extended; holds until the next load completes.
- `busy` out 1: state is not IDLE.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_din` out 32: RAM write data.
- `ram_dout` in 32: RAM read data, registered by the RAM and valid the cycle after a read-addressed edge.

## Operation
- Byte order is big-endian. Offset `addr[1:0]`=0 selects `[31:24]`, 3 selects `[7:0]`. Halfword offset 0 selects `[31:16]`, offset 2 selects `[15:0]`.
- In IDLE with `req`=1 the block latches `we`, `size`, `uns`, `addr` and `wdata`. `ram_addr` is set to `addr[ADDR_W+1:2]`.
- Error check happens at acceptance:
  - halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=11;
  - any `addr[31:ADDR_W+2]` bit set.
  - On error, go to DONE with `err`=1. The RAM is never touched.
- States: IDLE, WR, RD, CAP, DONE.
  - Word store: IDLE → WR → DONE.
  - Load: IDLE → RD → CAP → DONE.
  - Sub-word store: IDLE → RD → CAP → WR → DONE.
- RD drives `ram_we`=0 so the RAM registers the addressed word on that edge.
- CAP samples `ram_dout`.
  - Load: select the lane, extend it per `uns`, write to `rdata`.
  - Sub-word store: form a merged word by replacing only the addressed lane with `wdata[7:0]` or `wdata[15:0]`.
- WR asserts `ram_we`=1 for exactly one cycle, with `ram_din` = the full word or the merged word. `ram_we` is never asserted in any other state.
- DONE asserts `ack`=1 for one cycle, then returns to IDLE. `err` is 0 on success.
- `req` seen outside IDLE is ignored; it is not queued. A `req` held high starts a new transaction on the IDLE cycle after DONE.
- `ram_addr` and `ram_din` hold their values outside active states.

## Timing
- Reset, taking effect immediately:
  - state IDLE;
  - `ack`, `err`, `busy`, `ram_we` = 0;
  - `rdata`, `ram_addr`, `ram_din` = 0.
- Acceptance cycle is cycle 0. `ack` rises in:
  - cycle 1 for an error;
  - cycle 2 for a word store;
  - cycle 3 for a load;
  - cycle 4 for a sub-word store.
- `busy` is 1 from cycle 1 through the `ack` cycle inclusive.
- For loads, `rdata` is updated on the edge that enters DONE and is valid together with `ack`.
- Reset mid-transaction aborts it. No write is issued for an uncompleted RMW, `rdata` returns to 0, and no `ack` is produced.
- Every registered output, including `ram_we`, is a flop.

## Test plan
- Word store `addr`=0x10, `wdata`=0xDEADBEEF → `ram_we`=1 in cycle 1 with `ram_addr`=4, `ram_din`=0xDEADBEEF; `ack` in cycle 2. Then a word load of 0x10 → `rdata`=0xDEADBEEF, `ack` in cycle 3, `err`=0.
- Byte store 0xAA at 0x11 over 0xDEADBEEF → single `ram_we` in cycle 3 with `ram_din`=0xDEAABEEF; `ack` in cycle 4.
- Loads from word 0xDEAABEEF:
  - byte at 0x12, `uns`=0 → 0xFFFFFFBE;
  - byte at 0x12, `uns`=1 → 0x000000BE;
  - halfword at 0x10, `uns`=0 → 0xFFFFDEAA;
  - halfword at 0x12, `uns`=1 → 0x0000BEEF.
- Error requests: word at 0x12, halfword at 0x13, `size`=11, and word at 0x00004000 → each gives `ack`=`err`=1 in cycle 1; `ram_we` is never 1; `rdata` is unchanged.
- `rst` pulsed during CAP of a byte store → all outputs 0 asynchronously; no `ram_we`; a word read afterward returns the original contents.
- `req` held high across a word store then a load → the second transaction is accepted in the cycle after the first `ack`; `ack` pulses never merge.
